// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: read types, FSM states and
// the default word-array depth.
package mem_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;

  typedef enum logic [1:0] {
    RD_NONE = 2'b00,
    RD_WORD = 2'b01,
    RD_BYTE = 2'b10,
    RD_QTR  = 2'b11
  } rd_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } state_e;

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous RAM, 16-bit words, write-enable and registered read.
module dm_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [15:0]          wdata_i,
  output logic [15:0]          rdata_o
);

  logic [15:0] mem_q [2**ADDR_BITS];
  logic [15:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // control path around it is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one EX/MEM request, stalls upstream while it
// runs, and returns lane-selected, zero-extended read data with an rvalid pulse.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DataAddress,
  input  logic [1:0]  ReadMem,
  input  logic        WriteMem,
  input  logic [15:0] WriteData,
  input  logic [1:0]  quarter,
  output logic [15:0] ReadData,
  output logic [1:0]  o_quarter,
  output logic        rvalid,
  output logic        stall,
  output logic        err
);

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   addr_q;
  rd_type_e               rd_q;
  logic                   wr_q;
  logic [1:0]             quarter_q;
  logic [15:0]            wdata_q;
  logic [15:0]            read_data_q;
  logic [1:0]             o_quarter_q;
  logic                   rvalid_q;
  logic                   stall_q;
  logic                   err_q;

  logic                   ram_we;
  logic                   ram_re;
  logic [15:0]            ram_rdata;
  logic [15:0]            lane_data;
  logic                   request;

  // Address bits above the array index alias onto the low words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^DataAddress[15:ADDR_BITS];

  assign request = WriteMem || (ReadMem != RD_NONE);
  assign ram_we  = (state_q == ACCESS) && wr_q;
  assign ram_re  = (state_q == ACCESS) && !wr_q;

  dm_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lane_data = 16'h0000;
    unique case (rd_q)
      RD_WORD: lane_data = ram_rdata;
      RD_BYTE: lane_data = quarter_q[1] ? {8'h00, ram_rdata[15:8]}
                                        : {8'h00, ram_rdata[7:0]};
      RD_QTR:  lane_data = {12'h000, ram_rdata[{quarter_q, 2'b00} +: 4]};
      default: lane_data = 16'h0000;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_q        <= RD_NONE;
      wr_q        <= 1'b0;
      quarter_q   <= 2'b00;
      wdata_q     <= 16'h0000;
      read_data_q <= 16'h0000;
      o_quarter_q <= 2'b00;
      rvalid_q    <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (request) begin
            addr_q    <= DataAddress[ADDR_BITS-1:0];
            wr_q      <= WriteMem;
            // An illegal write+read keeps the write and drops the read.
            rd_q      <= WriteMem ? RD_NONE : rd_type_e'(ReadMem);
            quarter_q <= quarter;
            wdata_q   <= WriteData;
            err_q     <= WriteMem && (ReadMem != RD_NONE);
            stall_q   <= 1'b1;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr_q) begin
            stall_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= RESPOND;
          end
        end
        RESPOND: begin
          read_data_q <= lane_data;
          o_quarter_q <= quarter_q;
          rvalid_q    <= 1'b1;
          stall_q     <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReadData  = read_data_q;
  assign o_quarter = o_quarter_q;
  assign rvalid    = rvalid_q;
  assign stall     = stall_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized traffic against a word-array reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataAddress;
  logic [1:0]  ReadMem;
  logic        WriteMem;
  logic [15:0] WriteData;
  logic [1:0]  quarter;
  logic [15:0] ReadData;
  logic [1:0]  o_quarter;
  logic        rvalid;
  logic        stall;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [256];
  logic [7:0]  written_q [$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .WriteData   (WriteData),
    .quarter     (quarter),
    .ReadData    (ReadData),
    .o_quarter   (o_quarter),
    .rvalid      (rvalid),
    .stall       (stall),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected read result straight from the lane rules.
  function automatic logic [15:0] ref_read(input logic [15:0] w, input logic [1:0] rm,
                                           input logic [1:0] q);
    int sh;
    case (rm)
      2'b01:   return w;
      2'b10:   begin sh = q[1] ? 8 : 0; return (w >> sh) & 16'h00FF; end
      2'b11:   begin sh = 4 * int'(q); return (w >> sh) & 16'h000F; end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic idle_inputs();
    DataAddress = 16'h0000; ReadMem = 2'b00; WriteMem = 1'b0;
    WriteData = 16'h0000; quarter = 2'b00;
  endtask

  task automatic scramble_inputs();
    DataAddress = 16'($urandom); ReadMem = 2'($urandom); WriteMem = 1'($urandom);
    WriteData = 16'($urandom); quarter = 2'($urandom);
  endtask

  // Issue one request, garble inputs while stalled, and check the outcome
  // against the reference model over a fixed four-cycle window.
  task automatic do_req(input string tag, input logic [15:0] a, input logic [1:0] rm,
                        input logic wm, input logic [15:0] wd, input logic [1:0] q);
    int stall_cnt = 0, err_cnt = 0, rv_cnt = 0, rv_k = -1, err_k = -1;
    logic [15:0] rd_seen = 16'h0;
    logic [1:0]  oq_seen = 2'b00;
    logic        illegal;
    illegal = wm && (rm != 2'b00);
    @(negedge clk);
    DataAddress = a; ReadMem = rm; WriteMem = wm; WriteData = wd; quarter = q;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (stall) stall_cnt++;
      if (err) begin err_cnt++; err_k = k; end
      if (rvalid) begin rv_cnt++; rv_k = k; rd_seen = ReadData; oq_seen = o_quarter; end
      if (stall) scramble_inputs(); else idle_inputs();
      @(posedge clk); #1;
    end
    if (wm) begin
      check({tag, "_no_rvalid"}, rv_cnt, 0);
      check({tag, "_err_cnt"}, err_cnt, illegal ? 1 : 0);
      if (illegal) check({tag, "_err_in_access"}, err_k, 0);
      model[a[7:0]] = wd;
      written_q.push_back(a[7:0]);
    end else begin
      check({tag, "_rvalid_cnt"}, rv_cnt, 1);
      check({tag, "_latency"}, rv_k, 2);
      check({tag, "_stall_cycles"}, stall_cnt, 2);
      check({tag, "_data"}, rd_seen, ref_read(model[a[7:0]], rm, q));
      check({tag, "_oquarter"}, oq_seen, q);
      check({tag, "_no_err"}, err_cnt, 0);
    end
  endtask

  initial begin
    int rv_cnt;
    logic [15:0] rd_seen;
    logic [7:0]  pick;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_readdata", ReadData, 16'h0000);
    check("rst_oquarter", o_quarter, 2'b00);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Write then word read.
    do_req("wr_beef", 16'h0012, 2'b00, 1'b1, 16'hBEEF, 2'b00);
    do_req("rd_beef", 16'h0012, 2'b01, 1'b0, 16'h0000, 2'b00);

    // Lane selects on 0xA5C3.
    do_req("wr_a5c3", 16'h0005, 2'b00, 1'b1, 16'hA5C3, 2'b00);
    for (int q = 0; q < 4; q++) do_req("rd_qtr", 16'h0005, 2'b11, 1'b0, 16'h0, 2'(q));
    do_req("rd_byte_lo", 16'h0005, 2'b10, 1'b0, 16'h0, 2'b00);
    do_req("rd_byte_hi", 16'h0005, 2'b10, 1'b0, 16'h0, 2'b10);
    check("qtr3_const", ref_read(model[8'h05], 2'b11, 2'b11), 16'h000A);

    // Illegal write+read: write lands, read dropped.
    do_req("illegal", 16'h0007, 2'b01, 1'b1, 16'h1234, 2'b00);
    do_req("rd_after_illegal", 16'h0007, 2'b01, 1'b0, 16'h0, 2'b00);

    // Address alias.
    do_req("wr_alias", 16'h0103, 2'b00, 1'b1, 16'h5555, 2'b00);
    do_req("rd_alias", 16'h0003, 2'b01, 1'b0, 16'h0, 2'b00);

    // Read issued in the first IDLE cycle after a write sees the new data.
    do_req("wr_raw_old", 16'h0040, 2'b00, 1'b1, 16'h1111, 2'b00);
    @(negedge clk);
    DataAddress = 16'h0040; ReadMem = 2'b00; WriteMem = 1'b1; WriteData = 16'h2222;
    @(posedge clk); #1;
    DataAddress = 16'h0040; ReadMem = 2'b01; WriteMem = 1'b0;
    rv_cnt = 0; rd_seen = 16'h0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) idle_inputs();
      if (rvalid) begin rv_cnt++; rd_seen = ReadData; end
    end
    model[8'h40] = 16'h2222;
    check("raw_rvalid_cnt", rv_cnt, 1);
    check("raw_data", rd_seen, 16'h2222);

    // Reset while a read sits in ACCESS.
    @(negedge clk);
    DataAddress = 16'h0012; ReadMem = 2'b01; WriteMem = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    check("pre_rst_stall", stall, 1'b1);
    rst = 1'b1; #1;
    check("midrst_readdata", ReadData, 16'h0000);
    check("midrst_oquarter", o_quarter, 2'b00);
    check("midrst_rvalid", rvalid, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rvalid || stall) rv_cnt++;
    end
    check("post_rst_quiet", rv_cnt, 0);
    do_req("rd_after_rst", 16'h0012, 2'b01, 1'b0, 16'h0, 2'b00);

    // Randomized traffic; inputs are garbled during every stall window.
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        do_req("rnd_wr", 16'($urandom), 2'b00, 1'b1, 16'($urandom), 2'($urandom));
      end else if (sel == 3) begin
        do_req("rnd_illegal", 16'($urandom), 2'($urandom_range(1, 3)), 1'b1,
               16'($urandom), 2'($urandom));
      end else begin
        pick = written_q[$urandom_range(0, written_q.size() - 1)];
        do_req("rnd_rd", {8'($urandom), pick}, 2'($urandom_range(1, 3)), 1'b0,
               16'h0, 2'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
